// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing source. A clock-enable prescaler derives the pixel
// rate from the system clock; pixel counters, sync pulses and the frame tick
// are all registered so the connector pins see clean edges.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       game_reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DW-1:0] div;
  logic [9:0]    x_nxt, y_nxt;

  // Next counter position; syncs and frame tick are decoded from it so they
  // land in the same cycle as the counters they describe.
  always_comb begin
    x_nxt = (pixel_x == H_MAX) ? 10'd0 : pixel_x + 10'd1;
    y_nxt = pixel_y;
    if (pixel_x == H_MAX)
      y_nxt = (pixel_y == V_MAX) ? 10'd0 : pixel_y + 10'd1;
  end

  // Prescaler: p_tick goes high the cycle after div hits its terminal count.
  always_ff @(posedge clk) begin
    if (game_reset) begin
      div    <= '0;
      p_tick <= 1'b0;
    end else begin
      div    <= (div == DIV_MAX) ? '0 : div + 1'b1;
      p_tick <= (div == DIV_MAX);
    end
  end

  // Pixel counters and sync/frame outputs, advanced once per pixel period.
  always_ff @(posedge clk) begin
    if (game_reset) begin
      pixel_x    <= '0;
      pixel_y    <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      frame_tick <= 1'b0;
    end else if (p_tick) begin
      pixel_x    <= x_nxt;
      pixel_y    <= y_nxt;
      hsync      <= !((x_nxt >= HS_BEG) && (x_nxt <= HS_END));
      vsync      <= !((y_nxt >= VS_BEG) && (y_nxt <= VS_END));
      frame_tick <= (x_nxt == 10'd0) && (y_nxt == V_VIS);
    end else begin
      // Counters hold; the frame tick lasts a single clock.
      frame_tick <= 1'b0;
    end
  end

  // Visible-area decode straight off the counter registers.
  assign video_on = (pixel_x < H_VIS) && (pixel_y < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: two shortened-frame instances (CLK_DIV 4 and 2) checked
// every clock against a closed-form model driven by clocks since reset.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic game_reset;
  always #5 clk = ~clk;

  logic       hs1, vs1, von1, pt1, ft1;
  logic [9:0] x1, y1;
  logic       hs2, vs2, von2, pt2, ft2;
  logic [9:0] x2, y2;

  vga_sync_gen #(.CLK_DIV(4), .V_DISPLAY(10), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) u_dut1 (
    .clk(clk), .game_reset(game_reset), .hsync(hs1), .vsync(vs1), .video_on(von1),
    .p_tick(pt1), .frame_tick(ft1), .pixel_x(x1), .pixel_y(y1));

  vga_sync_gen #(.CLK_DIV(2), .V_DISPLAY(10), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) u_dut2 (
    .clk(clk), .game_reset(game_reset), .hsync(hs2), .vsync(vs2), .video_on(von2),
    .p_tick(pt2), .frame_tick(ft2), .pixel_x(x2), .pixel_y(y2));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs after k clocks since the last reset edge.
  // Packed {hsync, vsync, video_on, p_tick, frame_tick, x[9:0], y[9:0]}.
  function automatic logic [24:0] model(input int k, input int d, input int vd,
                                        input int vf, input int vsw, input int vt);
    int a, x, y;
    logic hs, vso, von, pt, ft;
    a   = (k >= 1) ? (k - 1) / d : 0;           // pixel advances so far
    x   = a % 800;
    y   = (a / 800) % vt;
    hs  = !(x >= 656 && x <= 751);
    vso = !(y >= vd + vf && y <= vd + vf + vsw - 1);
    von = (x < 640) && (y < vd);
    pt  = (k >= 1) && (k % d == 0);
    ft  = (k > d) && ((k - 1) % d == 0) && (x == 0) && (y == vd);
    return {hs, vso, von, pt, ft, 10'(x), 10'(y)};
  endfunction

  int   k = 0;
  logic armed = 1'b0;

  always @(posedge clk) begin
    if (game_reset) begin
      k     <= 0;
      armed <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  int cyc = 0;
  int last2 = -1;
  int n_per2 = 0;
  int ft1_cnt = 0;

  // Per-clock scoreboard for both instances, plus frame-length measurement.
  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      check("dut1_outs", {7'd0, hs1, vs1, von1, pt1, ft1, x1, y1}, {7'd0, model(k, 4, 10, 1, 1, 13)});
      check("dut2_outs", {7'd0, hs2, vs2, von2, pt2, ft2, x2, y2}, {7'd0, model(k, 2, 10, 1, 1, 13)});
      if (ft1) ft1_cnt++;
      if (game_reset) last2 = -1;
      else if (ft2) begin
        if (last2 >= 0) begin
          check("frame_len2", cyc - last2, 800 * 13 * 2);
          n_per2++;
        end
        last2 = cyc;
      end
    end
  end

  initial begin
    logic found, seen_ft;
    found   = 1'b0;
    seen_ft = 1'b0;
    game_reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    game_reset = 1'b0;

    // Prescaler start-up: first p_tick on clock 4, first pixel step after it.
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check("ptick_start", pt1, (j == 4));
    end
    @(negedge clk);
    check("x_first", x1, 1);
    check("y_first", y1, 0);

    // Walk the frame up to (700,11), probing visible-area and frame-tick edges.
    for (int n = 0; n < 60000; n++) begin
      @(negedge clk);
      if (x1 == 639 && y1 == 9)  check("von_639_9", von1, 1);
      if (x1 == 640 && y1 == 0)  check("von_640_0", von1, 0);
      if (x1 == 799 && y1 == 12) check("von_799_12", von1, 0);
      if (x1 == 0 && y1 == 10 && !seen_ft) begin
        check("ft_at_0_10", ft1, 1);
        check("von_0_10", von1, 0);
        seen_ft = 1'b1;
      end
      if (x1 == 700 && y1 == 11) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_700_11", found, 1);
    check("ft_seen", seen_ft, 1);
    check("ft1_count", ft1_cnt, 1);
    check("hs_low_700", hs1, 0);
    check("vs_low_11", vs1, 0);

    // Single-clock reset in the middle of both sync pulses.
    game_reset = 1'b1;
    @(negedge clk);
    game_reset = 1'b0;
    check("rst_x", x1, 0);
    check("rst_y", y1, 0);
    check("rst_hs", hs1, 1);
    check("rst_vs", vs1, 1);
    check("rst_pt", pt1, 0);
    check("rst_ft", ft1, 0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check("ptick_restart", pt1, (j == 4));
    end

    // Random run lengths and reset pulses; the scoreboard follows along.
    repeat (5) begin
      repeat ($urandom_range(3000, 50)) @(negedge clk);
      game_reset = 1'b1;
      repeat ($urandom_range(3, 1)) @(negedge clk);
      game_reset = 1'b0;
    end
    repeat (200) @(negedge clk);

    check("frame_len2_seen", (n_per2 >= 1), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
